// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder for the MEM-stage data bus.
// Accepts byte-strobed writes or reads and acks after a wait-state latency.
module data_mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] MWriteData,
  input  logic [3:0]  WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] MReadData,
  output logic        DataMem_Ready,
  output logic        Busy,
  output logic        ProtErr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [3:0] RL = READ_LATENCY[3:0];
  localparam logic [3:0] WL = WRITE_LATENCY[3:0];

  logic [31:0] ram [DEPTH];

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            we_q;
  logic                  rd_q;

  logic                  is_wr;
  logic                  req;
  logic [3:0]            lat;
  logic                  accept;
  logic                  fire_now;
  logic                  fire_wait;
  logic                  fire;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [31:0]           c_data;
  logic [3:0]            c_we;
  logic                  c_rd;
  logic                  unused_addr;

  assign in_idx = Address[ADDR_WIDTH+1:2];
  assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  assign is_wr  = |WriteEnable;
  assign req    = ReadEnable | is_wr;
  assign lat    = is_wr ? WL : RL;
  assign accept = (state == IDLE) && req;

  // A zero-latency op commits on its own accept edge, using live inputs.
  assign fire_now  = accept && (lat == 4'd0);
  assign fire_wait = (state == WAIT) && (cnt == 4'd0);
  assign fire      = fire_now | fire_wait;

  assign c_idx  = fire_now ? in_idx : idx_q;
  assign c_data = fire_now ? MWriteData : wdata_q;
  assign c_we   = fire_now ? WriteEnable : we_q;
  assign c_rd   = fire_now ? !is_wr : rd_q;

  assign DataMem_Ready = (state == ACK);
  assign Busy          = (state != IDLE);

  // Request sequencing: latch the request, count wait states, pulse ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= 4'd0;
      rd_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            idx_q   <= in_idx;
            wdata_q <= MWriteData;
            we_q    <= WriteEnable;
            rd_q    <= !is_wr;
            if (lat == 4'd0) begin
              state <= ACK;
            end else begin
              cnt   <= lat - 4'd1;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data and sticky protocol error; a read with a write strobe is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      MReadData <= 32'd0;
      ProtErr   <= 1'b0;
    end else begin
      if (fire && c_rd) begin
        MReadData <= ram[c_idx];
      end
      if (accept && ReadEnable && is_wr) begin
        ProtErr <= 1'b1;
      end
    end
  end

  // RAM byte-lane write at the commit edge; contents survive reset.
  always_ff @(posedge clock) begin
    if (fire && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (c_we[b]) begin
          ram[c_idx][8*b +: 8] <= c_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: default-latency and fast-read instances
// checked against an array-based memory model.
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic [31:0] ad   [2];
  logic [31:0] wd   [2];
  logic [3:0]  we_s [2];
  logic        re   [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        busy [2];
  logic        perr [2];

  int errs   = 0;
  int checks = 0;

  int          rlat [2] = '{2, 0};
  int          wlat [2] = '{1, 3};
  logic [31:0] mdl  [2][1024];
  bit          vld  [2][1024];
  bit          mperr [2];
  logic [31:0] lastrd [2];

  data_mem_responder u_def (
    .clock(clock), .reset(reset),
    .Address(ad[0]), .MWriteData(wd[0]),
    .WriteEnable(we_s[0]), .ReadEnable(re[0]),
    .MReadData(rdat[0]), .DataMem_Ready(rdy[0]),
    .Busy(busy[0]), .ProtErr(perr[0])
  );

  data_mem_responder #(
    .ADDR_WIDTH(10), .READ_LATENCY(0), .WRITE_LATENCY(3)
  ) u_fast (
    .clock(clock), .reset(reset),
    .Address(ad[1]), .MWriteData(wd[1]),
    .WriteEnable(we_s[1]), .ReadEnable(re[1]),
    .MReadData(rdat[1]), .DataMem_Ready(rdy[1]),
    .Busy(busy[1]), .ProtErr(perr[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drop(input int s);
    re[s]   = 1'b0;
    we_s[s] = 4'd0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mperr[s]  = 1'b0;
      lastrd[s] = 32'd0;
    end
  endtask

  // One bus transaction on instance s, checked against the model.
  task automatic access(input int s, input logic rd, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit hold);
    int n;
    int idx;
    int el;
    bit wr;
    logic [31:0] w;
    idx = int'(addr[11:2]);
    wr  = (we != 4'd0);
    el  = wr ? wlat[s] : rlat[s];
    @(negedge clock);
    re[s] = rd; we_s[s] = we; ad[s] = addr; wd[s] = data;
    @(posedge clock);
    #1;
    if (rd && wr) mperr[s] = 1'b1;
    chk("busy_accept", {31'd0, busy[s]}, 32'd1);
    if (!hold) drop(s);
    n = 0;
    while (!rdy[s] && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("latency", n, el);
    if (wr) begin
      w = vld[s][idx] ? mdl[s][idx] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (we[b]) w[8*b +: 8] = data[8*b +: 8];
      if (we != 4'hF && !vld[s][idx]) begin
        vld[s][idx] = 1'b0;
      end else begin
        mdl[s][idx] = w;
        vld[s][idx] = 1'b1;
      end
      chk("rdata_hold", rdat[s], lastrd[s]);
    end else if (vld[s][idx]) begin
      lastrd[s] = mdl[s][idx];
      chk("rdata", rdat[s], lastrd[s]);
    end else begin
      lastrd[s] = rdat[s];
    end
    chk("protErr", {31'd0, perr[s]}, {31'd0, mperr[s]});
    @(posedge clock);
    #1;
    if (hold) drop(s);
    chk("ready_width", {31'd0, rdy[s]}, 32'd0);
    chk("busy_idle", {31'd0, busy[s]}, 32'd0);
    if (hold) begin
      @(posedge clock);
      #1;
      chk("no_reaccept", {31'd0, rdy[s] | busy[s]}, 32'd0);
    end
  endtask

  initial begin
    logic [3:0] rwe;
    logic       rrd;
    int         rs;
    for (int s = 0; s < 2; s++) begin
      drop(s);
      ad[s] = 32'd0;
      wd[s] = 32'd0;
      for (int i = 0; i < 1024; i++) vld[s][i] = 1'b0;
    end
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", {31'd0, rdy[s]}, 32'd0);
      chk("rst_busy", {31'd0, busy[s]}, 32'd0);
      chk("rst_perr", {31'd0, perr[s]}, 32'd0);
      chk("rst_rdata", rdat[s], 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;

    access(0, 1'b0, 4'hF, 32'h40, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
    chk("word_rd", rdat[0], 32'hDEADBEEF);

    access(0, 1'b0, 4'hF, 32'h100, 32'h11223344, 1'b0);
    access(0, 1'b0, 4'b0001, 32'h100, 32'h000000AA, 1'b0);
    access(0, 1'b0, 4'b1000, 32'h100, 32'hBB000000, 1'b0);
    access(0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0);
    chk("byte_lanes", rdat[0], 32'hBB2233AA);

    access(1, 1'b0, 4'hF, 32'h20, 32'h0BADF00D, 1'b0);
    access(1, 1'b1, 4'h0, 32'h20, 32'h0, 1'b1);
    chk("fast_rd", rdat[1], 32'h0BADF00D);

    access(0, 1'b1, 4'hF, 32'h80, 32'h5A5A5A5A, 1'b0);
    access(0, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0);
    chk("both_strobe_wr", rdat[0], 32'h5A5A5A5A);
    chk("perr_sticky", {31'd0, perr[0]}, 32'd1);

    access(0, 1'b0, 4'hF, 32'h10, 32'h01020304, 1'b0);
    @(negedge clock);
    re[0] = 1'b0; we_s[0] = 4'hF; ad[0] = 32'h10; wd[0] = 32'hCAFEF00D;
    @(posedge clock);
    #1;
    drop(0);
    chk("wait_busy", {31'd0, busy[0]}, 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("abort_ready", {31'd0, rdy[0]}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    chk("perr_cleared", {31'd0, perr[0]}, 32'd0);
    access(0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    chk("abort_keep", rdat[0], 32'h01020304);

    access(0, 1'b0, 4'hF, 32'h0000_0004, 32'h12345678, 1'b0);
    access(0, 1'b1, 4'h0, 32'h0000_1004, 32'h0, 1'b0);
    chk("alias", rdat[0], 32'h12345678);

    for (int i = 0; i < 60; i++) begin
      rs  = int'($urandom_range(0, 1));
      rwe = 4'($urandom);
      rrd = 1'($urandom);
      if (rwe == 4'd0) rrd = 1'b1;
      access(rs, rrd, rwe, $urandom & 32'hFFFF_F03F, $urandom,
             bit'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the data-memory bus driven by the MEM-stage memory controller.
- Accepts a one-bit read strobe or a 4-bit byte write strobe, a 32-bit address and 32-bit write data, and performs the access on an internal word-organised RAM.
- Adds a configurable wait-state latency, then returns a single-cycle ready pulse, with read data held stable.
- Used as the data-memory model in the CPU testbench and as the on-chip scratch data RAM.

Parameters:
- ADDR_WIDTH, 10, word-index bits; RAM depth = 2^ADDR_WIDTH 32-bit words.
- READ_LATENCY, 2, wait cycles between read request acceptance and ready pulse (0..15).
- WRITE_LATENCY, 1, wait cycles between write request acceptance and ready pulse (0..15).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- Address  input  32  byte address; bits [ADDR_WIDTH+1:2] index the RAM, bits [1:0] and above-index bits are ignored.
- MWriteData  input  32  write data, byte lanes already aligned by the controller.
- WriteEnable  input  4  per-byte write strobe; [3] covers bits 31:24 … [0] covers bits 7:0.
- ReadEnable  input  1  read strobe.
- MReadData  output  32  read data returned to the controller.
- DataMem_Ready  output  1  one-cycle completion pulse.
- Busy  output  1  high while a request is accepted and not yet acknowledged (WAIT or ACK).
- ProtErr  output  1  sticky; set when ReadEnable and a nonzero WriteEnable are sampled together.

Behaviour:
- Reset (reset=0, async): state=IDLE, DataMem_Ready=0, Busy=0, ProtErr=0, MReadData=0, wait counter=0. RAM contents are not cleared.
- Request = ReadEnable | (WriteEnable != 0). Requests are sampled only in IDLE; strobes in WAIT/ACK are ignored.
- States:
  - IDLE: on a request at edge k, latch Address index, MWriteData, WriteEnable and op type.
    - Op latency L = 0: go to ACK.
    - Otherwise: load counter = L-1 and go to WAIT.
  - WAIT: decrement counter each cycle; at counter==0 go to ACK.
  - ACK: DataMem_Ready=1 for exactly this cycle, then IDLE unconditionally.
- Timing: DataMem_Ready is high in cycle k+1+L (L=0 gives ack the cycle after the request is sampled).
- Commit point: the access executes on the edge entering ACK.
  - Write: only the latched byte lanes are updated.
  - Read: MReadData loads RAM[index] and is valid throughout ACK.
- MReadData holds its last read value until the next read commits; writes never disturb it.
- Simultaneous read and write strobes: the write wins, the read is dropped, latency = WRITE_LATENCY, ProtErr is set (cleared only by reset).
- Back-to-back requests: the controller drops its strobes the cycle after ready. Strobes still high in the ACK cycle are not accepted. A request present in the first IDLE cycle after ACK is accepted, so the minimum request spacing is L+2 cycles.
- Reset mid-operation: the access is aborted, no RAM write occurs, and no ready is issued.
- Address wrap: index = Address[ADDR_WIDTH+1:2]; higher address bits alias.
- Busy = (state != IDLE).

Test Plan:
- Word write then read at 0x40, default latencies: write 0xDEADBEEF, WE=4'b1111 → ready in cycle k+2; read → ready in cycle k+3 with MReadData=0xDEADBEEF.
- Byte lanes: preload 0x11223344, write 0x000000AA with WE=4'b0001, then 0xBB000000 with WE=4'b1000 → read returns 0xBB2233AA.
- READ_LATENCY=0: read request → ready the very next cycle; ready is exactly 1 cycle wide; strobes held high in the ACK cycle produce no second ready.
- Simultaneous ReadEnable=1 and WE=4'b1111 to 0x80 with data 0x5A5A5A5A → memory written, ProtErr=1 and remains set, ready after WRITE_LATENCY.
- Reset pulled low in WAIT of a write of 0xCAFEF00D to 0x10 → DataMem_Ready stays 0, Busy=0 immediately, later read of 0x10 returns the prior value.
- Aliasing (ADDR_WIDTH=10): write 0x12345678 to 0x0000_0004, read 0x0000_1004 → 0x12345678.
